// File: rtl/sysarr_host_sequencer.sv
// Host-side driver for the 8x8 bit-serial systolic array: holds operands, feeds the
// skewed in1/in2 byte stream, then shifts the result rows out into a local file.
module sysarr_host_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [2:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic         start,
    input  logic         mode_xor,
    output logic         busy,
    output logic         done,
    input  logic [2:0]   rd_addr,
    output logic [N-1:0] rd_data,
    output logic [7:0]   arr_data,
    output logic [7:0]   arr_ctl,
    input  logic [7:0]   arr_result
);
    localparam int SW = 5;
    localparam logic [SW-1:0] S_LAST = SW'(3*N-2);
    localparam logic [3:0]    R_LAST = 4'(N);

    typedef enum logic [2:0] {IDLE, FEED_A, FEED_B, READ, DONE} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] s;
    logic [3:0]    r;
    logic          mode_q;
    logic [N-1:0]  p_mem [N];
    logic [N-1:0]  q_mem [N];
    logic [N-1:0]  res   [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            s      <= '0;
            r      <= '0;
            mode_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                p_mem[k] <= '0;
                q_mem[k] <= '0;
                res[k]   <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (wr_sel) q_mem[wr_addr] <= wr_data;
                        else        p_mem[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        mode_q <= mode_xor;
                        s      <= '0;
                    end
                end
                FEED_B: begin
                    if (s == S_LAST) r <= '0;
                    else             s <= s + 1'b1;
                end
                READ: begin
                    // Rows leave the array last-row-first, one per readout cycle.
                    if (r != 4'd0) res[3'(R_LAST - r)] <= arr_result[N-1:0];
                    r <= r + 1'b1;
                end
                DONE: begin
                    s <= '0;
                    r <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FEED_A;
            FEED_A:  state_nx = FEED_B;
            FEED_B:  state_nx = (s == S_LAST) ? READ : FEED_A;
            READ:    if (r == R_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Skewed feed: lane j carries operand word s-j, so every cell sees matching k.
    logic [SW-1:0] d;
    always_comb begin
        arr_data = 8'h00;
        d        = '0;
        for (int j = 0; j < N; j++) begin
            d = s - SW'(j);
            if (s >= SW'(j) && d < SW'(N)) begin
                if (state == FEED_A) arr_data[j] = p_mem[d[2:0]][j];
                if (state == FEED_B) arr_data[j] = q_mem[d[2:0]][j];
            end
        end
    end

    logic readout, usexor;
    assign readout = (state == IDLE) || (state == READ) || (state == DONE);
    assign usexor  = (state != IDLE) && mode_q;
    assign arr_ctl = {2'b00, 3'b000, usexor, readout, 1'b0};

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign rd_data = res[rd_addr];
endmodule

// File: tb/tb_sysarr_host_sequencer.sv
// Bench for sysarr_host_sequencer: a behavioural array model answers the feed stream,
// and results are compared against the matrix reduction computed from the operands.
module tb_sysarr_host_sequencer;
    localparam int N = 8;

    logic       clk = 1'b0, reset = 1'b1;
    logic       wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, mode_xor = 1'b0;
    logic [2:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, done;
    logic [7:0] rd_data, arr_data, arr_ctl, arr_result;

    sysarr_host_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .mode_xor(mode_xor), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .arr_data(arr_data), .arr_ctl(arr_ctl),
        .arr_result(arr_result)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [7:0] gp [8];
    logic [7:0] gq [8];

    // Array model: column j's in1 bit travels down i rows, row i's in2 bit travels
    // across j columns, so cell (i,j) pairs in1[t-i] with in2[t-j] at step t.
    logic [7:0] m_in1 [32];
    logic [7:0] m_in2 [32];
    logic [7:0] m_c   [8];
    logic [7:0] m_hold;
    int         m_n = 0, m_rc = N + 1;
    bit         m_ph = 0, m_x = 0;

    function automatic logic [7:0] arr_row(int i);
        logic [7:0] row = '0;
        for (int j = 0; j < N; j++) begin
            logic acc = 1'b0;
            for (int t = 0; t < m_n && t < 32; t++) begin
                logic a = (t >= i) ? m_in1[t-i][j] : 1'b0;
                logic b = (t >= j) ? m_in2[t-j][i] : 1'b0;
                acc = m_x ? (acc ^ (a & b)) : (acc | (a & b));
            end
            row[j] = acc;
        end
        return row;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_n <= 0; m_ph <= 0; m_rc <= N + 1;
            for (int i = 0; i < N; i++) m_c[i] <= '0;
        end else if (!arr_ctl[1]) begin
            m_rc <= 0;
            m_ph <= !m_ph;
            if (!m_ph) m_hold <= arr_data;
            else begin
                if (m_n < 32) begin
                    m_in1[m_n] <= m_hold;
                    m_in2[m_n] <= arr_data;
                end
                m_n <= m_n + 1;
                m_x <= arr_ctl[2];
            end
        end else begin
            m_ph <= 0;
            if (m_rc == 0) begin
                for (int i = 0; i < N; i++) m_c[i] <= arr_row(i);
                m_n <= 0;
            end
            if (m_rc <= N) m_rc <= m_rc + 1;
        end
    end

    assign arr_result = (m_rc >= 1 && m_rc <= N) ? m_c[N-m_rc] : 8'h00;

    function automatic logic [7:0] gold(int i, bit x);
        logic [7:0] row = '0;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++)
                row[j] = x ? (row[j] ^ (gp[k][j] & gq[k][i])) : (row[j] | (gp[k][j] & gq[k][i]));
        return row;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(bit sel, int a, logic [7:0] dat);
        wr_en = 1; wr_sel = sel; wr_addr = 3'(a); wr_data = dat;
        step();
        wr_en = 0;
        if (sel) gq[a] = dat; else gp[a] = dat;
    endtask

    // Start a job; optionally carry one operand write in the same IDLE cycle.
    task automatic launch(bit x, bit do_wr, bit sel, int a, logic [7:0] dat);
        start = 1; mode_xor = x;
        wr_en = do_wr; wr_sel = sel; wr_addr = 3'(a); wr_data = dat;
        step();
        start = 0; wr_en = 0; mode_xor = ~x;
        if (do_wr) begin
            if (sel) gq[a] = dat; else gp[a] = dat;
        end
    endtask

    task automatic wait_done(string tag, int cyc0);
        int cyc = cyc0;
        bit busy_ok = 1, rsvd_ok = 1;
        while (!done && cyc < 120) begin
            if (!busy) busy_ok = 0;
            if ((arr_ctl & 8'hF9) != 0) rsvd_ok = 0;
            step();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 56);
        chk({tag, "_busy"}, {busy_ok, busy}, 2'b11);
        chk({tag, "_rsvd"}, {rsvd_ok, arr_ctl & 8'hF9}, {1'b1, 8'h00});
        step();
        chk({tag, "_idle_ctl"}, {busy, done, arr_ctl, arr_result}, {2'b00, 8'h02, 8'h00});
    endtask

    task automatic check_res(string tag, bit x);
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i); #1;
            chk($sformatf("%s_row%0d", tag, i), rd_data, gold(i, x));
        end
    endtask

    task automatic load_identity();
        for (int k = 0; k < N; k++) begin
            wr(0, k, 8'(1 << k));
            wr(1, k, 8'(1 << k));
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin gp[k] = '0; gq[k] = '0; end
        repeat (3) step();
        reset = 0;
        chk("reset_outs", {busy, done, arr_ctl, arr_data}, {2'b00, 8'h02, 8'h00});
        check_res("reset_res", 0);

        load_identity();
        launch(0, 0, 0, 0, 8'h00);
        wait_done("ident", 1);
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i); #1;
            chk($sformatf("ident_row%0d", i), rd_data, 32'(1 << i));
        end

        for (int k = 0; k < N; k++) begin wr(0, k, 8'hFF); wr(1, k, 8'hFF); end
        launch(0, 0, 0, 0, 8'h00);
        wait_done("ones_or", 1);
        check_res("ones_or", 0);
        launch(1, 0, 0, 0, 8'h00);
        wait_done("ones_xor", 1);
        check_res("ones_xor", 1);
        launch(1, 1, 1, 7, 8'h00);
        wait_done("ones_xor_q7", 1);
        check_res("ones_xor_q7", 1);

        for (int n = 0; n < 50; n++) begin
            bit x = 1'($urandom);
            if (n % 2 == 0) begin
                for (int w = 0; w < 15; w++) wr(w[3], w % 8, 8'($urandom));
                launch(x, 1, 1, 7, 8'($urandom));
            end else begin
                launch(x, 0, 0, 0, 8'h00);
            end
            wait_done($sformatf("rnd%0d", n), 1);
            check_res($sformatf("rnd%0d", n), x);
        end

        load_identity();
        launch(0, 0, 0, 0, 8'h00);
        repeat (9) step();
        start = 1; wr_en = 1; wr_sel = 0; wr_addr = 3'd2; wr_data = 8'hA5;
        step();
        start = 0; wr_en = 0;
        wr_en = 1; wr_sel = 1; wr_addr = 3'd5; wr_data = 8'h3C;
        step();
        wr_en = 0;
        wait_done("midfeed", 12);
        check_res("midfeed", 0);

        for (int k = 0; k < N; k++) begin wr(0, k, 8'($urandom)); wr(1, k, 8'($urandom)); end
        launch(1, 0, 0, 0, 8'h00);
        repeat (21) step();
        chk("pre_reset_feed", {busy, arr_ctl[1]}, 2'b10);
        reset = 1;
        step();
        chk("post_reset_outs", {busy, done, arr_ctl, arr_data}, {2'b00, 8'h02, 8'h00});
        reset = 0;
        for (int k = 0; k < N; k++) begin gp[k] = '0; gq[k] = '0; end
        check_res("post_reset_res", 0);
        launch(0, 0, 0, 0, 8'h00);
        wait_done("cleared_ops", 1);
        check_res("cleared_ops", 0);
        load_identity();
        launch(0, 0, 0, 0, 8'h00);
        wait_done("ident2", 1);
        check_res("ident2", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sysarr_host_sequencer.md
Name: sysarr_host_sequencer

Overview:
- Host-side initiator for the 8x8 bit-serial systolic matrix engine in the chip top.
- Takes two operand matrices from a local register-file write port.
- Generates the skewed, alternating in1/in2 byte stream on the array's data input, then drives the readout sequence.
- Captures the N result rows into a local result file and signals completion. Used in the FPGA/bench harness and as a reusable driver for the chip top.

Parameters:
- N, 8, array dimension; operand and result word width, and number of rows per matrix.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  operand write strobe
- wr_sel  in  1  0=P matrix, 1=Q matrix
- wr_addr  in  3  operand word index k
- wr_data  in  N  operand word
- start  in  1  launch a job
- mode_xor  in  1  0=OR-reduce, 1=XOR-reduce; latched at start
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- done  out  1  one-cycle completion pulse
- rd_addr  in  3  result row index
- rd_data  out  N  result row rd_addr, combinational from the result file
- arr_data  out  8  drives the array data input (ui_in)
- arr_ctl  out  8  drives the array control input (uio_in): {2'b00, yes=0, no=0, adventure=0, usexor, readout, sayhi=0}
- arr_result  in  8  array output (uo_out)

Behaviour:
- Math: C[i][j] = reduce_k (P[k][j] & Q[k][i]), k=0..N-1; reduce is OR or XOR per the latched mode. Result row i = C[i][N-1:0].
- States: IDLE, FEED_A, FEED_B, READ, DONE.
- Counters:
  - step s: 0..3N-2 (23 steps for N=8).
  - read r: 0..N.
- IDLE:
  - arr_data=0; arr_ctl readout=1, usexor=0.
  - Holding readout clears the array accumulators and pins the array's pair phase to "expect in1 next".
  - start=1 → latch mode_xor, s=0, go FEED_A.
- FEED_A (array captures in1):
  - arr_data bit j = P[s-j][j] if 0<=s-j<N, else 0.
  - readout=0, usexor=latched mode.
  - Go to FEED_B.
- FEED_B (array consumes the pair):
  - arr_data bit i = Q[s-i][i] if 0<=s-i<N, else 0.
  - If s=3N-2: go READ with r=0. Otherwise s+1, go FEED_A.
  - The trailing zero steps flush the in1 shift path, so all out1 registers are 0 before readout.
- READ:
  - readout=1, arr_data=0, usexor=latched mode.
  - At each clock edge with r>=1, sample arr_result into res[N-r]. Row N-1 appears at r=1 and row 0 at r=N.
  - r increments each cycle. After r=N, go DONE.
- DONE: done=1, busy=1, readout=1. Go IDLE.
- Latency:
  - start sampled at edge E0; first FEED_A cycle follows E0.
  - Feed is 2(3N-1)=46 cycles, READ is N+1=9 cycles.
  - done is high in cycle 56 after E0.
- Writes:
  - Accepted only in IDLE; ignored while busy.
  - A write and start in the same IDLE cycle: the write lands first, and the job uses the new value.
- start while busy: ignored; no queuing.
- rd_data: res is stable except during READ captures. Reading while busy returns the previous job's rows until overwritten.
- Reset (any state, including mid-feed or mid-read):
  - State IDLE, counters 0, done=0, busy=0, arr_data=0, arr_ctl=8'h02.
  - Operand and result files cleared to 0.
  - The array shares the same reset, so phase stays aligned.
- All arr_* outputs are registered, or decoded from registered state only; no combinational path from start or wr_* to arr_*.

Test Plan:
- Identity: P[k]=Q[k]=1<<k, OR mode → res[i]=1<<i for all i; done exactly 56 cycles after start edge.
- All-ones: P=Q=8'hFF. OR mode → every res=8'hFF. XOR mode (8 ones per term) → every res=8'h00. Q[7]=0 in XOR → every res=8'hFF.
- Random P,Q, 50 jobs back-to-back (start asserted in the cycle after done), both modes, against a bench golden model through the real array top → zero mismatches; no residue from prior jobs.
- start pulsed and wr_en with new data mid-feed → ignored; result equals the original operands; busy stays high continuously.
- reset asserted at FEED_B s=10, then a fresh identity job → correct identity result; arr_ctl=8'h02 and arr_data=0 in the cycle after reset.
- In IDLE, arr_ctl bit1=1 and arr_result=0; in all states, sayhi/adventure/yes/no bits are never asserted.
